hex_scan_ctrl: RTL and testbench



---
 rtl/hex_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_hex_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Seven-segment scan controller: a buffered value is committed at frame wraps, then shown one digit at a time with dead time between digits.
// Optional macro HEX_LEADING_ZERO_BLANK_EN keeps leading-zero digits (above digit 0) dark.
module hex_scan_ctrl #(
  parameter int NUM_DIGITS  = 6,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [3:0]              hex_nibble,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);
  localparam int DW      = 4 * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [3:0]            hex_nibble_q, hex_nibble_d;
  logic                  frame_done_q, frame_done_d;

  logic                  blank_end, show_end, wrap;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lit;

  assign blank_end = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
  assign show_end  = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST);
  assign wrap      = show_end && (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (blank_end) begin
      state_d = ST_SHOW;
      cnt_d   = '0;
    end else if (show_end) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = wrap ? '0 : idx_q + 1'b1;
    end
    // Transfer and commit are exclusive: a transfer needs pending low, a commit needs it high.
    if (load_valid && !pending_q) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi] = disp_d[4*gi +: 4];
`ifdef HEX_LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_first
        assign lit[gi] = 1'b1;
      end else begin : g_upper
        assign lit[gi] = |disp_d[DW-1:4*gi];
      end
`else
      assign lit[gi] = 1'b1;
`endif
    end
  endgenerate

  // Outputs are registered from next-state values so they line up with state.
  always_comb begin
    digit_sel_d  = '1;
    hex_nibble_d = '0;
    frame_done_d = wrap;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        hex_nibble_d = nib[i];
        if ((state_d == ST_SHOW) && lit[i]) digit_sel_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      digit_sel_q  <= '1;
      hex_nibble_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      digit_sel_q  <= digit_sel_d;
      hex_nibble_q <= hex_nibble_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = ~pending_q;
  assign digit_sel  = digit_sel_q;
  assign hex_nibble = hex_nibble_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: time-based display model checked every cycle, plus directed literal checks.
module tb_hex_scan_ctrl;
  localparam int ND    = 6;
  localparam int SD    = 4;
  localparam int DC    = 1;
  localparam int SLOT  = SD + DC;
  localparam int FRAME = ND * SLOT;

`ifdef HEX_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [23:0] load_data = '0;
  logic        load_ready;
  logic [3:0]  hex_nibble;
  logic [5:0]  digit_sel;
  logic        frame_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  hex_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .Clk(Clk), .Reset(Reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .hex_nibble(hex_nibble), .digit_sel(digit_sel),
    .frame_done(frame_done)
  );

  // Model: t_m counts cycles since reset; slot/phase follow from t_m, commits at multiples of FRAME.
  int          t_m = 0;
  logic [23:0] disp_m = '0;
  logic [23:0] shadow_m = '0;
  logic        pending_m = 1'b0;
  bit          model_ok = 1'b0;

  always @(posedge Clk) begin
    if (Reset) begin
      t_m       <= 0;
      disp_m    <= '0;
      shadow_m  <= '0;
      pending_m <= 1'b0;
      model_ok  <= 1'b1;
    end else begin
      t_m <= t_m + 1;
      if (load_valid && !pending_m) begin
        shadow_m  <= load_data;
        pending_m <= 1'b1;
        $display("load accepted t=%0d data=%h", t_m, load_data);
      end
      if (((t_m + 1) % FRAME == 0) && pending_m) begin
        disp_m    <= shadow_m;
        pending_m <= 1'b0;
        $display("commit t=%0d data=%h", t_m + 1, shadow_m);
      end
    end
  end

  function automatic bit lit_m(input int dig, input logic [23:0] d);
    if (!LZ || dig == 0) return 1'b1;
    return (d >> (4 * dig)) != 24'd0;
  endfunction

  function automatic logic [5:0] exp_sel(input int t, input logic [23:0] d);
    int p;
    int dig;
    logic [5:0] s;
    p   = t % FRAME;
    dig = p / SLOT;
    s   = '1;
    if ((p % SLOT) != 0 && lit_m(dig, d)) s[dig] = 1'b0;
    return s;
  endfunction

  function automatic logic [3:0] exp_nib(input int t, input logic [23:0] d);
    logic [23:0] sh;
    sh = d >> (4 * ((t % FRAME) / SLOT));
    return sh[3:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%h expected=%h", nm, t_m, act, exp);
  endtask

  always @(negedge Clk) begin
    if (model_ok) begin
      chk("model_sel", 32'(digit_sel), 32'(exp_sel(t_m, disp_m)));
      chk("model_nib", 32'(hex_nibble), 32'(exp_nib(t_m, disp_m)));
      chk("model_frame_done", 32'(frame_done), 32'((t_m > 0) && (t_m % FRAME == 0)));
      chk("model_ready", 32'(load_ready), 32'(!pending_m));
    end
  end

  task automatic goto(input int n);
    int guard;
    guard = 0;
    @(negedge Clk);
    while (t_m != n && guard < 500) begin
      @(negedge Clk);
      guard++;
    end
    if (t_m != n) begin
      n_total++;
      $display("FAIL goto t=%0d target=%0d", t_m, n);
    end
  endtask

  initial begin
    int first_fd;
    int seen7;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    // Cycle 0 after the last reset edge: reset values.
    chk("rst_sel", 32'(digit_sel), 32'h3F);
    chk("rst_nib", 32'(hex_nibble), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    goto(1);  chk("first_lit", 32'(digit_sel), 32'h3E);
    goto(4);  chk("d0_last_show", 32'(digit_sel), 32'h3E);
    goto(5);  chk("d1_blank", 32'(digit_sel), 32'h3F);
    first_fd = -1;
    while (t_m < 40) begin
      @(negedge Clk);
      if (frame_done && first_fd < 0) first_fd = t_m;
    end
    chk("first_frame_done", 32'(first_fd), 32'd30);

    // Mid-frame load; a second request while pending is ignored.
    goto(42); load_valid = 1'b1; load_data = 24'hABC123;
    goto(43); chk("ready_drop", 32'(load_ready), 32'h0); load_data = 24'h111111;
    goto(55); load_valid = 1'b0;
    goto(59); chk("old_display", 32'(hex_nibble), 32'h0);
    goto(60); chk("wrap_fd", 32'(frame_done), 32'h1);
    goto(61); chk("ready_back", 32'(load_ready), 32'h1);
              chk("abc_d0_sel", 32'(digit_sel), 32'h3E);
              chk("abc_d0", 32'(hex_nibble), 32'h3);
    goto(66); chk("abc_d1", 32'(hex_nibble), 32'h2);
    goto(71); chk("abc_d2", 32'(hex_nibble), 32'h1);
    goto(76); chk("abc_d3", 32'(hex_nibble), 32'hC);
    goto(81); chk("abc_d4", 32'(hex_nibble), 32'hB);
    goto(86); chk("abc_d5", 32'(hex_nibble), 32'hA);
              chk("abc_d5_sel", 32'(digit_sel), 32'h1F);

    // Load in the last SHOW cycle of digit 5: held over to the next wrap.
    goto(89); load_valid = 1'b1; load_data = 24'h5A5A5A;
    goto(90); load_valid = 1'b0;
              chk("late_ready", 32'(load_ready), 32'h0);
    goto(91); chk("late_not_committed", 32'(hex_nibble), 32'h3);
    goto(121); chk("late_committed_d0", 32'(hex_nibble), 32'hA);
    goto(126); chk("late_committed_d1", 32'(hex_nibble), 32'h5);

    // Reset during SHOW of digit 3 with a pending value.
    load_valid = 1'b1; load_data = 24'h777777;
    goto(127); load_valid = 1'b0; chk("pend_ready", 32'(load_ready), 32'h0);
    goto(137); chk("d3_show_sel", 32'(digit_sel), 32'h37);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_rst_sel", 32'(digit_sel), 32'h3F);
    chk("mid_rst_nib", 32'(hex_nibble), 32'h0);
    chk("mid_rst_ready", 32'(load_ready), 32'h1);
    chk("mid_rst_fd", 32'(frame_done), 32'h0);
    seen7 = 0;
    while (t_m < 70) begin
      @(negedge Clk);
      if (hex_nibble == 4'h7) seen7++;
    end
    chk("shadow_discarded", 32'(seen7), 32'd0);

    // Leading-zero behaviour (all digits lit when the option is off).
    goto(72); load_valid = 1'b1; load_data = 24'h000042;
    goto(73); load_valid = 1'b0;
    goto(91); chk("lz_d0_sel", 32'(digit_sel), 32'h3E);
              chk("lz_d0", 32'(hex_nibble), 32'h2);
              load_valid = 1'b1; load_data = 24'h000000;
    goto(92); load_valid = 1'b0;
    goto(96); chk("lz_d1_sel", 32'(digit_sel), 32'h3D);
              chk("lz_d1", 32'(hex_nibble), 32'h4);
    goto(101); chk("lz_d2_sel", 32'(digit_sel), LZ ? 32'h3F : 32'h3B);
    goto(116); chk("lz_d5_sel", 32'(digit_sel), LZ ? 32'h3F : 32'h1F);
    goto(121); chk("zero_d0_sel", 32'(digit_sel), 32'h3E);
               chk("zero_d0", 32'(hex_nibble), 32'h0);
    goto(126); chk("zero_d1_sel", 32'(digit_sel), LZ ? 32'h3F : 32'h3D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
